// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package imem_pkg;

  localparam int IMEM_DEPTH_WORDS = 1024;
  localparam int IMEM_WORD_W      = 32;
  localparam int BYTES_PER_WORD   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_TRAIL,
    ST_DONE
  } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Big-endian byte-to-word assembler: first byte of a word lands in [31:24].
module imem_word_packer
  import imem_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear_i,
  input  logic                   byte_en_i,
  input  logic [7:0]             byte_i,
  output logic [IMEM_WORD_W-1:0] word_o,
  output logic                   word_full_o
);

  logic [1:0]               idx_q, idx_d;
  logic [IMEM_WORD_W-9:0]   shift_q, shift_d;

  always_comb begin
    idx_d   = idx_q;
    shift_d = shift_q;
    if (clear_i) begin
      idx_d   = '0;
      shift_d = '0;
    end else if (byte_en_i) begin
      idx_d   = idx_q + 2'd1;
      shift_d = {shift_q[IMEM_WORD_W-17:0], byte_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Word as it stands including the byte on the bus; only meaningful with word_full_o.
  assign word_o      = {shift_q, byte_i};
  assign word_full_o = byte_en_i && (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams a byte-wide program image into instruction memory, holding the CPU in reset.
// Optional trailer checksum check enabled by IMEM_LOADER_CHECKSUM_EN.
//   state    | meaning
//   ST_IDLE  | waiting for first start
//   ST_RECV  | accepting bytes of the current word
//   ST_WRITE | single-cycle memory write of the assembled word
//   ST_TRAIL | accepting the 4-byte expected checksum (checksum build only)
//   ST_DONE  | load finished or rejected; done/err held
module imem_loader
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter int CNT_W       = 11
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             cpu_hold
);

  localparam logic [CNT_W-1:0] DEPTH_LIM = CNT_W'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [CNT_W-1:0]        idx_q, idx_d;
  logic                    mem_we_q, mem_we_d;
  logic [31:0]             addr_q, addr_d;
  logic [IMEM_WORD_W-1:0]  wdata_q, wdata_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [IMEM_WORD_W-1:0]  csum_q, csum_d;
`endif

  logic                    accept;
  logic                    pack_clear;
  logic [IMEM_WORD_W-1:0]  pack_word;
  logic                    pack_full;

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign byte_ready = (state_q == ST_RECV) || (state_q == ST_TRAIL);
`else
  assign byte_ready = (state_q == ST_RECV);
`endif
  assign accept = byte_valid && byte_ready;

  imem_word_packer u_packer (
    .clk        (clk),
    .rst_n      (reset_n),
    .clear_i    (pack_clear),
    .byte_en_i  (accept),
    .byte_i     (byte_data),
    .word_o     (pack_word),
    .word_full_o(pack_full)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    mem_we_d   = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    err_d      = err_q;
    pack_clear = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          count_d    = word_count;
          idx_d      = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          pack_clear = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
          if (word_count == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (word_count > DEPTH_LIM) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = ST_RECV;
          end
        end
      end
      // Write strobe is registered here so it lands in the cycle the FSM sits in WRITE.
      ST_RECV: begin
        if (pack_full) begin
          state_d  = ST_WRITE;
          mem_we_d = 1'b1;
          addr_d   = {{(32-CNT_W-2){1'b0}}, idx_q, 2'b00};
          wdata_d  = pack_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d   = csum_q ^ pack_word;
`endif
        end
      end
      ST_WRITE: begin
        idx_d = idx_q + CNT_ONE;
        if (idx_q + CNT_ONE == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = ST_TRAIL;
`else
          state_d = ST_DONE;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = ST_RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_TRAIL: begin
        if (pack_full) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          err_d   = (pack_word != csum_q);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      idx_q    <= '0;
      mem_we_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      mem_we_q <= mem_we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign done      = done_q;
  assign err       = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign busy      = (state_q == ST_RECV) || (state_q == ST_WRITE) || (state_q == ST_TRAIL);
`else
  assign busy      = (state_q == ST_RECV) || (state_q == ST_WRITE);
`endif
  assign cpu_hold  = busy;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader with a byte source and instruction-memory model.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int CNT_W = 11;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [CNT_W-1:0] word_count;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready, mem_we, busy, done, err, cpu_hold;
  logic [31:0]      mem_addr, mem_wdata;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0]  src_q[$];
  bit          gap_mode = 1'b0;
  int          n_accepted = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] csum_model;
  int          ready_in_write = 0;
  logic [31:0] imem [0:1023];

  always #5 clk = ~clk;

  imem_loader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .word_count(word_count),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cpu_hold  (cpu_hold)
  );

  always @(posedge clk) begin
    if (mem_we === 1'b1) begin
      imem[mem_addr[11:2]] <= mem_wdata;
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  always @(negedge clk) begin
    if (mem_we === 1'b1 && byte_ready !== 1'b0) ready_in_write++;
  end

  // Byte source: holds a presented byte until it is taken; optional random idle gaps.
  initial begin
    bit xfer;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    forever begin
      @(posedge clk);
      xfer = (byte_valid === 1'b1) && (byte_ready === 1'b1);
      #1;
      if (xfer) begin
        void'(src_q.pop_front());
        n_accepted++;
        byte_valid = 1'b0;
      end
      if (src_q.size() == 0) byte_valid = 1'b0;
      if (!byte_valid && src_q.size() > 0 && (!gap_mode || $urandom_range(0, 1) == 1)) begin
        byte_valid = 1'b1;
        byte_data  = src_q[0];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic new_load();
    wr_addr_q.delete();
    wr_data_q.delete();
    exp_q.delete();
    csum_model = 32'h0;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) src_q.push_back(w[31-8*b -: 8]);
    exp_q.push_back(w);
    csum_model = csum_model ^ w;
  endtask

  task automatic push_trailer();
`ifdef IMEM_LOADER_CHECKSUM_EN
    for (int b = 0; b < 4; b++) src_q.push_back(csum_model[31-8*b -: 8]);
`endif
  endtask

  task automatic pulse_start(input logic [CNT_W-1:0] n);
    @(negedge clk);
    start      = 1'b1;
    word_count = n;
    @(negedge clk);
    start      = 1'b0;
    word_count = 11'h7FF;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (done !== 1'b1 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    check("done_within_budget", 32'(done), 32'h1);
  endtask

  task automatic wait_src_empty(input int budget);
    int c;
    c = 0;
    while (src_q.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("source_drained", 32'(src_q.size()), 32'h0);
  endtask

  task automatic check_log(input string tag);
    check({tag, "_nwrites"}, 32'(wr_addr_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_addr_q.size(); i++) begin
      check({tag, "_addr"}, wr_addr_q[i], 32'(i * 4));
      check({tag, "_data"}, wr_data_q[i], exp_q[i]);
    end
  endtask

  initial begin
    int cyc;
    int n0;
    reset_n    = 1'b1;
    start      = 1'b0;
    word_count = '0;
    #2 reset_n = 1'b0;
    #1;
    check("reset_ctrl", {26'h0, byte_ready, mem_we, busy, done, err, cpu_hold}, 32'h0);
    check("reset_addr", mem_addr, 32'h0);
    check("reset_wdata", mem_wdata, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Three-word load, byte_valid never drops.
    new_load();
    push_word(32'h00000013);
    push_word(32'h00100093);
    push_word(32'hDEADBEEF);
    push_trailer();
    pulse_start(11'd3);
    check("t1_busy_hold_ready", {29'h0, busy, cpu_hold, byte_ready}, 32'h7);
    wait_done(200, cyc);
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("t1_cycles", 32'(cyc), 32'd19);
`else
    check("t1_cycles", 32'(cyc), 32'd15);
`endif
    check("t1_flags", {28'h0, done, err, busy, cpu_hold}, 32'h8);
    check_log("t1");
    check("t1_rd0", imem[0], 32'h00000013);
    check("t1_rd1", imem[1], 32'h00100093);
    check("t1_rd2", imem[2], 32'hDEADBEEF);

    // Bytes offered in DONE must stall at the source.
    src_q.push_back(8'hAA);
    n0 = n_accepted;
    repeat (10) @(negedge clk);
    check("done_stall_accepted", 32'(n_accepted - n0), 32'h0);
    check("done_stall_ready", 32'(byte_ready), 32'h0);
    src_q.delete();
    repeat (2) @(negedge clk);

    // Sixteen words with random gaps.
    new_load();
    for (int i = 0; i < 16; i++)
      push_word({8'(i), 8'hC3 ^ 8'(i), 8'(i * 7), 8'h5A});
    push_trailer();
    n0 = n_accepted;
    gap_mode = 1'b1;
    pulse_start(11'd16);
    wait_done(2000, cyc);
    gap_mode = 1'b0;
    check_log("t2");
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("t2_bytes", 32'(n_accepted - n0), 32'd68);
`else
    check("t2_bytes", 32'(n_accepted - n0), 32'd64);
`endif
    check("t2_ready_in_write", 32'(ready_in_write), 32'h0);
    check("t2_err", 32'(err), 32'h0);

    // Count boundaries.
    new_load();
    pulse_start(11'd0);
    check("zero_flags", {28'h0, done, err, busy, cpu_hold}, 32'h8);
    repeat (5) @(negedge clk);
    check("zero_nwrites", 32'(wr_addr_q.size()), 32'h0);
    pulse_start(11'd1025);
    check("over_flags", {28'h0, done, err, busy, cpu_hold}, 32'hC);
    repeat (5) @(negedge clk);
    check("over_nwrites", 32'(wr_addr_q.size()), 32'h0);
    pulse_start(11'd1024);
    check("max_flags", {28'h0, done, err, busy, cpu_hold}, 32'h3);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("max_nwrites", 32'(wr_addr_q.size()), 32'h0);

    // Start during a load is ignored.
    new_load();
    push_word(32'hCAFEF00D);
    push_word(32'h0BADC0DE);
    push_trailer();
    pulse_start(11'd2);
    repeat (2) @(negedge clk);
    pulse_start(11'd5);
    check("midstart_busy", 32'(busy), 32'h1);
    wait_done(200, cyc);
    check_log("t3");
    check("t3_err", 32'(err), 32'h0);

    // Reset after two bytes of word index 5 of 8.
    new_load();
    for (int i = 0; i < 5; i++) push_word(32'h10000000 + 32'(i) * 32'h01010101);
    src_q.push_back(8'h77);
    src_q.push_back(8'h88);
    pulse_start(11'd8);
    wait_src_empty(400);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_ctrl", {26'h0, byte_ready, mem_we, busy, done, err, cpu_hold}, 32'h0);
    check("abort_addr", mem_addr, 32'h0);
    check("abort_wdata", mem_wdata, 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check_log("t4");

    new_load();
    for (int i = 0; i < 8; i++) push_word(32'hA0000000 | 32'(i * 3 + 1));
    push_trailer();
    pulse_start(11'd8);
    wait_done(400, cyc);
    check_log("t5");
    check("t5_rd5", imem[5], 32'hA0000010);

`ifdef IMEM_LOADER_CHECKSUM_EN
    for (int k = 0; k < 2; k++) begin
      new_load();
      push_word(32'h11111111);
      push_word(32'h22222222);
      src_q.push_back(8'h33);
      src_q.push_back(8'h33);
      src_q.push_back(8'h33);
      pulse_start(11'd2);
      wait_src_empty(200);
      repeat (3) @(negedge clk);
      check("cs_wait_trailer", {30'h0, done, busy}, 32'h1);
      src_q.push_back(k == 0 ? 8'h33 : 8'h34);
      wait_done(50, cyc);
      check("cs_err", 32'(err), 32'(k));
      check_log("cs");
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart to the instruction memory read port. Streams a program image into instruction memory over a byte-wide valid/ready channel, e.g. from a testbench UART model or host bridge.
- Assembles bytes into 32-bit words and issues single-cycle word writes at byte addresses 0, 4, 8, … so a read at `address/4` returns word N.
- Holds the CPU in reset while loading.

Parameters:
- DEPTH_WORDS, 1024, instruction memory capacity in words.
- CNT_W, 11, width of word_count; must satisfy 2^CNT_W > DEPTH_WORDS.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load; sampled only in IDLE or DONE.
- word_count  in  CNT_W  number of words to load; latched on accepted start.
- byte_valid  in  1  source has a byte.
- byte_data  in  8  byte payload.
- byte_ready  out  1  loader accepts a byte this cycle.
- mem_we  out  1  instruction memory write enable, one cycle per word.
- mem_addr  out  32  byte address of the write, always a multiple of 4.
- mem_wdata  out  32  word to write.
- busy  out  1  load in progress.
- done  out  1  load finished; held until next accepted start.
- err  out  1  load rejected or failed; held until next accepted start.
- cpu_hold  out  1  keep CPU in reset; high while busy.

Behaviour:
- Reset (async, reset_n=0): state=IDLE. All outputs 0: byte_ready, mem_we, mem_addr, mem_wdata, busy, done, err, cpu_hold. Internal byte, word and count registers are cleared.
- Handshake: a byte transfers when byte_valid && byte_ready at a rising edge. byte_ready is a pure function of state (high only in RECV, and in TRAIL when the optional feature is enabled). It never depends on byte_valid.
- IDLE / DONE on start=1:
  - Latch word_count, clear done/err, set word index=0 and byte index=0.
  - If word_count==0: go to DONE, done=1, no writes.
  - If word_count>DEPTH_WORDS: go to DONE, done=1, err=1, no writes.
  - Otherwise go to RECV; busy=cpu_hold=1 from the next cycle.
- RECV: byte_ready=1. Bytes are assembled big-endian: byte 0 goes to [31:24], byte 3 to [7:0]. On the 4th accepted byte, go to WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr=word_index*4, mem_wdata=assembled word; all registered outputs. byte_ready=0.
  - Next cycle: mem_we=0 and word_index increments.
  - If word_index+1==latched count: go to DONE, or TRAIL if the optional feature is enabled. Otherwise return to RECV.
- mem_addr and mem_wdata hold their last values outside WRITE.
- Latency: the 4th byte is accepted at edge N; mem_we is high in cycle N+1; the next byte can be accepted at edge N+2 at the earliest. Peak throughput is 4 bytes per 5 cycles.
- DONE: busy=0, cpu_hold=0, done=1 held. byte_ready=0, so extra bytes stall at the source and are never consumed.
- A start pulse while busy is ignored.
- word_count changes after latch have no effect.
- byte_valid may drop mid-word; the partial word is held indefinitely with no timeout.
- Reset asserted mid-load aborts immediately. Words already written stay in memory. No partial write is ever issued.
- Last valid address is (DEPTH_WORDS-1)*4. The word index never wraps because of the count check at start.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of all written words is kept, cleared on start.
  - After the last WRITE, state TRAIL accepts 4 more bytes (big-endian) as the expected checksum. No memory write is issued for it.
  - On the 4th trailer byte, go to DONE with done=1. err=1 if the checksum mismatches, else err=0.
  - The word_count==0 case skips TRAIL.
- Not defined: no TRAIL state and no checksum logic; DONE follows the last WRITE directly.

Decomposition:
- Shared package imem_pkg:
  - IMEM_DEPTH_WORDS=1024, IMEM_WORD_W=32.
  - State encoding constants: ST_IDLE, ST_RECV, ST_WRITE, ST_TRAIL, ST_DONE.
  - BYTES_PER_WORD=4.
- Sub-module imem_word_packer: 2-bit byte index, shift register, word_full flag; cleared by the FSM.
- Top module: FSM, word counter, address generation, checksum.

Test Plan:
- Load 3 words (bytes 00 00 00 13, 00 10 00 93, DE AD BE EF) with byte_valid held high. Expect:
  - mem_we pulses at addresses 0, 4, 8 with data 00000013, 00100093, DEADBEEF.
  - done=1 and cpu_hold=0 after the third write.
  - A read-back through the instruction memory returns the same words at addresses 0, 4, 8.
- Random byte_valid gaps (about 50% duty) on a 16-word image. Expect:
  - Identical writes to the gap-free case.
  - byte_ready=0 during every WRITE cycle.
  - No byte lost or duplicated.
- word_count=0 gives done=1, err=0, no mem_we. word_count=1025 gives done=1, err=1, no mem_we.
- start pulsed during a load gives no effect.
- reset_n low after 2 bytes of word 5 of 8. Expect:
  - All outputs 0 immediately, with no write to address 20.
  - A new start reloads cleanly from address 0.
- IMEM_LOADER_CHECKSUM_EN with 2 words 11111111 and 22222222:
  - Trailer 33333333 gives err=0.
  - Trailer 33333334 gives err=1.
  - In both cases done=1 only after the 4th trailer byte.
